aes_mode_engine: RTL and testbench

- Parametrised successor to the single-block AES encrypt/decrypt wrapper.
- Adds ECB, CBC and CTR chaining modes, valid/ready streaming, a small output FIFO and a request/done handshake to an external AES core.
- Sits between the crypto processor's data bus and the AES encrypt/decrypt cores, one block in flight at a time.
- Key, IV and mode are latched by a config pulse; every subsequent block uses them until reconfigured.

---
 rtl/aes_mode_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_aes_mode_engine.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mode_engine.sv
// aes_mode_engine: ECB/CBC/CTR chaining wrapper around an external AES core.
// One block in flight at a time; results land in a small output FIFO.
module aes_mode_engine #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned KEY_W   = 128,
  parameter int unsigned CTR_W   = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_E_Db,
  input  logic [KEY_W-1:0]   cfg_key,
  input  logic [BLOCK_W-1:0] cfg_iv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               core_start,
  output logic               core_dec,
  output logic [KEY_W-1:0]   core_key,
  output logic [BLOCK_W-1:0] core_data,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result,
  output logic               busy,
  output logic               cfg_err,
  output logic               done,
  output logic [31:0]        blk_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_POST = 2'd3;

  localparam logic [1:0] M_ECB = 2'b00;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;
  localparam logic [1:0] M_RSV = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               enc_q, enc_d;
  logic [1:0]         mode_q, mode_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [BLOCK_W-1:0] res_q, res_d;
  logic               configured_q, configured_d;
  logic               cfg_err_q, cfg_err_d;
  logic               core_start_q, core_start_d;
  logic               core_dec_q, core_dec_d;
  logic [BLOCK_W-1:0] core_data_q, core_data_d;
  logic               done_q, done_d;
  logic [31:0]        blk_cnt_q, blk_cnt_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;
  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [BLOCK_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               accept;
  logic               push;
  logic               pop;
  logic [BLOCK_W-1:0] push_data;

  // Config gating happens a cycle early in in_ready_q; a same-cycle cfg_load still wins.
  assign in_ready = in_ready_q & ~cfg_load;

  // Next-state logic: FSM, chaining datapath and FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    enc_d        = enc_q;
    mode_d       = mode_q;
    chain_d      = chain_q;
    data_d       = data_q;
    res_d        = res_q;
    configured_d = configured_q;
    cfg_err_d    = cfg_err_q;
    core_start_d = 1'b0;
    core_dec_d   = core_dec_q;
    core_data_d  = core_data_q;
    done_d       = 1'b0;
    blk_cnt_d    = blk_cnt_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    push         = 1'b0;
    push_data    = '0;
    accept       = in_valid & in_ready;
    pop          = out_valid_q & out_ready;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          key_d        = cfg_key;
          enc_d        = cfg_E_Db;
          mode_d       = (cfg_mode == M_RSV) ? M_ECB : cfg_mode;
          chain_d      = cfg_iv;
          configured_d = 1'b1;
          cfg_err_d    = (cfg_mode == M_RSV);
        end else if (accept) begin
          data_d       = in_data;
          core_start_d = 1'b1;
          state_d      = S_REQ;
          unique case (mode_q)
            M_CBC: begin
              core_data_d = enc_q ? (in_data ^ chain_q) : in_data;
              core_dec_d  = ~enc_q;
            end
            M_CTR: begin
              core_data_d = chain_q;
              core_dec_d  = 1'b0;
            end
            default: begin
              core_data_d = in_data;
              core_dec_d  = ~enc_q;
            end
          endcase
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          res_d   = core_result;
          done_d  = 1'b1;
          state_d = S_POST;
        end
      end
      default: begin
        push      = 1'b1;
        blk_cnt_d = blk_cnt_q + 32'd1;
        state_d   = S_IDLE;
        unique case (mode_q)
          M_CBC: begin
            if (enc_q) begin
              push_data = res_q;
              chain_d   = res_q;
            end else begin
              push_data = res_q ^ chain_q;
              chain_d   = data_q;
            end
          end
          M_CTR: begin
            push_data            = data_q ^ res_q;
            chain_d[CTR_W-1:0]   = chain_q[CTR_W-1:0] + CTR_W'(1);
          end
          default: begin
            push_data = res_q;
          end
        endcase
      end
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    busy_d      = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_IDLE) & configured_d & (count_d < CNT_W'(DEPTH));
    out_valid_d = (count_d != '0);
    out_data_d  = mem_d[rd_ptr_d];
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      enc_q        <= 1'b1;
      mode_q       <= M_ECB;
      chain_q      <= '0;
      data_q       <= '0;
      res_q        <= '0;
      configured_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      core_start_q <= 1'b0;
      core_dec_q   <= 1'b0;
      core_data_q  <= '0;
      done_q       <= 1'b0;
      blk_cnt_q    <= '0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      enc_q        <= enc_d;
      mode_q       <= mode_d;
      chain_q      <= chain_d;
      data_q       <= data_d;
      res_q        <= res_d;
      configured_q <= configured_d;
      cfg_err_q    <= cfg_err_d;
      core_start_q <= core_start_d;
      core_dec_q   <= core_dec_d;
      core_data_q  <= core_data_d;
      done_q       <= done_d;
      blk_cnt_q    <= blk_cnt_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign core_start = core_start_q;
  assign core_dec   = core_dec_q;
  assign core_key   = key_q;
  assign core_data  = core_data_q;
  assign busy       = busy_q;
  assign cfg_err    = cfg_err_q;
  assign done       = done_q;
  assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_aes_mode_engine.sv
// tb_aes_mode_engine: directed + random checks of aes_mode_engine against a
// mode-level reference model, with a stand-in AES core of random latency.
module tb_aes_mode_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_load;
  logic [1:0]   cfg_mode;
  logic         cfg_E_Db;
  logic [127:0] cfg_key;
  logic [127:0] cfg_iv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         core_start;
  logic         core_dec;
  logic [127:0] core_key;
  logic [127:0] core_data;
  logic         core_done;
  logic         core_done_auto;
  logic         core_done_man;
  logic [127:0] core_result;
  logic         busy;
  logic         cfg_err;
  logic         done;
  logic [31:0]  blk_cnt;

  assign core_done = core_done_auto | core_done_man;

  always #5 clk = ~clk;

  aes_mode_engine #(.BLOCK_W(128), .KEY_W(128), .CTR_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_E_Db(cfg_E_Db),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .core_dec(core_dec), .core_key(core_key), .core_data(core_data),
    .core_done(core_done), .core_result(core_result), .busy(busy), .cfg_err(cfg_err),
    .done(done), .blk_cnt(blk_cnt)
  );

  localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MIX = 128'h5a3c96e1_0f1e2d3c_4b5a6978_8796a5b4;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Stand-in cipher: the FIPS-197 vector is honoured exactly, everything else
  // goes through an invertible toy permutation.
  function automatic logic [127:0] toy_enc(input logic [127:0] k, input logic [127:0] x);
    logic [127:0] y;
    if (k == FK && x == FP) return FC;
    y = x ^ k;
    return {y[120:0], y[127:121]} ^ MIX;
  endfunction

  function automatic logic [127:0] toy_dec(input logic [127:0] k, input logic [127:0] y);
    logic [127:0] z;
    if (k == FK && y == FC) return FP;
    z = y ^ MIX;
    return {z[6:0], z[127:7]} ^ k;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model state.
  int           m_mode;
  bit           m_enc;
  logic [127:0] m_key;
  logic [127:0] m_chain;
  logic [127:0] exp_q[$];
  int           exp_blk = 0;

  task automatic model_cfg(input int mode, input bit enc, input logic [127:0] key,
                           input logic [127:0] iv);
    m_mode  = (mode == 3) ? 0 : mode;
    m_enc   = enc;
    m_key   = key;
    m_chain = iv;
  endtask

  task automatic model_blk(input logic [127:0] d);
    logic [127:0] o;
    case (m_mode)
      1: begin
        if (m_enc) begin o = toy_enc(m_key, d ^ m_chain); m_chain = o; end
        else begin o = toy_dec(m_key, d) ^ m_chain; m_chain = d; end
      end
      2: begin
        o = d ^ toy_enc(m_key, m_chain);
        m_chain[31:0] = m_chain[31:0] + 32'd1;
      end
      default: o = m_enc ? toy_enc(m_key, d) : toy_dec(m_key, d);
    endcase
    exp_q.push_back(o);
    exp_blk++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Stand-in AES core: samples its request, replies after 1..4 cycles.
  bit           auto_core = 1'b1;
  logic [127:0] last_cd   = '0;
  logic         last_dec  = 1'b0;
  int           stable_err = 0;
  int           done_cnt   = 0;

  initial begin
    logic [127:0] cd;
    logic [127:0] k;
    logic         dec;
    int           lat;
    core_done_auto = 1'b0;
    core_result    = '0;
    forever begin
      @(negedge clk);
      core_done_auto = 1'b0;
      if (core_start && auto_core && !rst) begin
        cd = core_data; dec = core_dec; k = core_key;
        last_cd = cd; last_dec = dec;
        lat = $urandom_range(1, 4);
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (core_data !== cd || core_dec !== dec) stable_err++;
        end
        core_result    = dec ? toy_dec(k, cd) : toy_enc(k, cd);
        core_done_auto = 1'b1;
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Drive a config strobe for one cycle; model follows only when honoured.
  task automatic do_cfg(input int mode, input bit enc, input logic [127:0] key,
                        input logic [127:0] iv);
    cfg_load = 1'b1; cfg_mode = 2'(mode); cfg_E_Db = enc; cfg_key = key; cfg_iv = iv;
    @(negedge clk);
    cfg_load = 1'b0;
    model_cfg(mode, enc, key, iv);
  endtask

  task automatic try_send(input logic [127:0] d, input int budget, output bit ok);
    int n;
    in_valid = 1'b1; in_data = d; n = 0;
    #1;
    while (!in_ready && n < budget) begin @(negedge clk); n++; end
    ok = in_ready;
    if (ok) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [127:0] d);
    bit ok;
    try_send(d, 60, ok);
    if (!ok) chk({tag, "_accept_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic drain_one(input string tag);
    int n;
    logic [127:0] e;
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    if (!out_valid) chk({tag, "_out_timeout"}, 128'd0, 128'd1);
    else if (exp_q.size() == 0) chk({tag, "_unexpected_out"}, out_data, 128'd0);
    else begin
      e = exp_q.pop_front();
      chk(tag, out_data, e);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [127:0] pt [3];
    logic [127:0] ct [3];
    logic [127:0] prev;
    logic [127:0] iv;
    logic [127:0] k;
    logic [127:0] d;
    int acc;
    int dc0;
    bit ok;

    rst = 1'b1; cfg_load = 1'b0; cfg_mode = 2'b00; cfg_E_Db = 1'b1; cfg_key = '0; cfg_iv = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; core_done_man = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_in_ready",   128'(in_ready),   128'd0);
    chk("rst_out_valid",  128'(out_valid),  128'd0);
    chk("rst_out_data",   out_data,         128'd0);
    chk("rst_core_start", 128'(core_start), 128'd0);
    chk("rst_core_dec",   128'(core_dec),   128'd0);
    chk("rst_core_key",   core_key,         128'd0);
    chk("rst_core_data",  core_data,        128'd0);
    chk("rst_busy",       128'(busy),       128'd0);
    chk("rst_cfg_err",    128'(cfg_err),    128'd0);
    chk("rst_done",       128'(done),       128'd0);
    chk("rst_blk_cnt",    128'(blk_cnt),    128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unconfigured engine refuses blocks.
    in_valid = 1'b1; in_data = rnd128(); #1;
    chk("unconfigured_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk); in_valid = 1'b0;
    chk("unconfigured_busy", 128'(busy), 128'd0);

    // ECB encrypt, FIPS-197 vector.
    do_cfg(0, 1'b1, FK, '0);
    chk("ecb_core_key", core_key, FK);
    send("fips", FP); model_blk(FP);
    drain_one("fips_out");
    chk("fips_out_literal", FC, exp_blk == 1 ? FC : 128'd0);
    chk("fips_done_cnt", 128'(done_cnt), 128'd1);
    chk("fips_blk_cnt",  128'(blk_cnt),  128'd1);

    // ECB random encrypt and decrypt.
    k = rnd128();
    do_cfg(0, 1'b1, k, '0);
    for (int i = 0; i < 3; i++) begin
      d = rnd128(); send("ecb_enc", d); model_blk(d); drain_one("ecb_enc_out");
    end
    do_cfg(0, 1'b0, k, '0);
    for (int i = 0; i < 2; i++) begin
      d = rnd128(); send("ecb_dec", d); model_blk(d); drain_one("ecb_dec_out");
      chk("ecb_dec_core_dec", 128'(last_dec), 128'd1);
    end

    // CBC encrypt three blocks; next core input proves chain = last ciphertext.
    k  = rnd128();
    iv = 128'h0f0e0d0c0b0a09080706050403020100;
    do_cfg(1, 1'b1, k, iv);
    prev = iv;
    for (int i = 0; i < 3; i++) begin
      pt[i] = rnd128();
      send("cbc_enc", pt[i]); model_blk(pt[i]);
      ct[i] = exp_q[exp_q.size() - 1];
      drain_one("cbc_enc_out");
      chk("cbc_enc_core_data", last_cd, pt[i] ^ prev);
      prev = ct[i];
    end
    // CBC decrypt must recover the plaintexts.
    do_cfg(1, 1'b0, k, iv);
    for (int i = 0; i < 3; i++) begin
      send("cbc_dec", ct[i]); exp_q.push_back(pt[i]); exp_blk++;
      drain_one("cbc_dec_roundtrip");
      chk("cbc_dec_core_data", last_cd, ct[i]);
    end

    // CTR with low-word wrap.
    k  = rnd128();
    iv = {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'hffffffff};
    do_cfg(2, 1'b1, k, iv);
    for (int i = 0; i < 2; i++) begin
      pt[i] = rnd128();
      send("ctr_enc", pt[i]); model_blk(pt[i]);
      ct[i] = exp_q[exp_q.size() - 1];
      drain_one("ctr_enc_out");
      chk("ctr_enc_core_dec", 128'(last_dec), 128'd0);
    end
    chk("ctr_wrap_counter", last_cd, {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'h00000000});
    do_cfg(2, 1'b0, k, iv);
    for (int i = 0; i < 2; i++) begin
      send("ctr_dec", ct[i]); exp_q.push_back(pt[i]); exp_blk++;
      drain_one("ctr_dec_roundtrip");
      chk("ctr_dec_core_dec", 128'(last_dec), 128'd0);
    end

    // Backpressure: FIFO of 4 fills, fifth and sixth are refused.
    do_cfg(0, 1'b1, rnd128(), '0);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      d = rnd128();
      try_send(d, 30, ok);
      if (ok) begin acc++; model_blk(d); end
    end
    repeat (10) @(negedge clk);
    chk("bp_accepted", 128'(acc), 128'd4);
    in_valid = 1'b1; #1;
    chk("bp_in_ready_full", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    drain_one("bp_out0");
    chk("bp_in_ready_after_pop", 128'(in_ready), 128'd1);
    for (int i = 1; i < 4; i++) drain_one("bp_out");
    chk("bp_empty", 128'(out_valid), 128'd0);

    // cfg_load and in_valid together: config wins.
    k = rnd128();
    cfg_load = 1'b1; cfg_mode = 2'b00; cfg_E_Db = 1'b1; cfg_key = k; cfg_iv = '0;
    in_valid = 1'b1; in_data = rnd128(); #1;
    chk("cfg_vs_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0; model_cfg(0, 1'b1, k, '0);
    chk("cfg_vs_in_busy", 128'(busy), 128'd0);
    chk("cfg_vs_in_key", core_key, k);
    @(negedge clk);
    chk("cfg_vs_in_blk_cnt", 128'(blk_cnt), 128'(exp_blk));

    // cfg_load during WAIT is ignored.
    d = rnd128(); send("cfg_wait", d); model_blk(d);
    @(negedge clk);
    chk("cfg_wait_busy", 128'(busy), 128'd1);
    cfg_load = 1'b1; cfg_mode = 2'b11; cfg_key = ~k;
    @(negedge clk);
    cfg_load = 1'b0;
    drain_one("cfg_wait_out");
    chk("cfg_wait_key", core_key, k);
    chk("cfg_wait_err", 128'(cfg_err), 128'd0);

    // Reserved mode: error flag and ECB behaviour; cleared by a valid load.
    k = rnd128();
    do_cfg(3, 1'b1, k, rnd128());
    chk("rsv_cfg_err", 128'(cfg_err), 128'd1);
    d = rnd128(); send("rsv", d); model_blk(d); drain_one("rsv_ecb_out");
    chk("rsv_core_data", last_cd, d);
    do_cfg(0, 1'b1, k, '0);
    chk("rsv_cfg_err_clear", 128'(cfg_err), 128'd0);
    chk("blk_cnt_total", 128'(blk_cnt), 128'(exp_blk));
    chk("done_cnt_total", 128'(done_cnt), 128'(exp_blk));
    chk("core_data_stable", 128'(stable_err), 128'd0);

    // Reset during WAIT, then a stray core_done.
    auto_core = 1'b0;
    dc0 = done_cnt;
    send("rst_wait", rnd128());
    @(negedge clk);
    chk("rst_wait_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    core_done_man = 1'b1; core_result = rnd128();
    @(negedge clk);
    core_done_man = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b1; #1;
    chk("abort_in_ready",  128'(in_ready),  128'd0);
    in_valid = 1'b0;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_blk_cnt",   128'(blk_cnt),   128'd0);
    chk("abort_busy",      128'(busy),      128'd0);
    chk("abort_done_cnt",  128'(done_cnt),  128'(dc0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
